// File: rtl/imm_extend_unit.sv
// Pipelined immediate extender: zero/sign/upper/branch-offset extension with a
// registered in_ready and a two-entry (main + skid) output buffer.
module imm_extend_unit #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    // Encoding is {skid_full, main_full}.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StFull  = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [OUT_W-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [TAG_W-1:0]   main_tag_q, main_tag_d, skid_tag_q, skid_tag_d;
    logic [OUT_W-1:0]   zext, sext, ext;
    logic               accept, drain;

    assign zext = OUT_W'(in_imm);
    assign sext = OUT_W'($signed(in_imm));

    always_comb begin
        ext = zext;
        unique case (in_mode)
            2'd0: ext = zext;
            2'd1: ext = sext;
            2'd2: ext = zext << (OUT_W - IN_W);
            2'd3: ext = sext << 2;
            default: ext = zext;
        endcase
    end

    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_data_q;
    assign out_tag   = main_tag_q;
    assign in_ready  = in_ready_q;
    assign accept    = in_valid & in_ready_q;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_tag_d  = main_tag_q;
        skid_data_d = skid_data_q;
        skid_tag_d  = skid_tag_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    main_data_d = ext;
                    main_tag_d  = in_tag;
                    state_d     = StOne;
                end
            end
            StOne: begin
                if (accept && drain) begin
                    main_data_d = ext;
                    main_tag_d  = in_tag;
                end else if (accept) begin
                    skid_data_d = ext;
                    skid_tag_d  = in_tag;
                    state_d     = StFull;
                end else if (drain) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // in_ready is low here, so only a drain can happen.
                if (drain) begin
                    main_data_d = skid_data_q;
                    main_tag_d  = skid_tag_q;
                    skid_data_d = '0;
                    skid_tag_d  = '0;
                    state_d     = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        in_ready_d = (state_d != StFull);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            main_data_q <= '0;
            main_tag_q  <= '0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_data_q <= main_data_d;
            main_tag_q  <= main_tag_d;
            skid_data_q <= skid_data_d;
            skid_tag_q  <= skid_tag_d;
        end
    end

endmodule

// File: doc/imm_extend_unit.md
# imm_extend_unit

Parametrised, pipelined immediate-extension stage for the datapath, generalising the fixed 16→32 zero extender. Each accepted immediate is extended under a per-transaction mode (zero, sign, upper-load, branch-offset). The result is presented one cycle later on a valid/ready output. A two-entry skid buffer lets the decode stage keep issuing while the consumer stalls, and registered `in_ready` keeps the downstream ready path out of upstream timing.

## Interface
- `IN_W`, 16: immediate width; legal range ≥ 2.
- `OUT_W`, 32: extended width; must be ≥ `IN_W`.
- `TAG_W`, 5: sideband tag width, e.g. a destination register number. The tag is passed through unchanged.
- `Clk` in 1: clock. All state updates on the rising edge.
- `Rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream presents a transaction.
- `in_ready` out 1: unit can accept. Registered output.
- `in_imm` in `IN_W`: raw immediate.
- `in_mode` in 2: 0 zero-ext, 1 sign-ext, 2 upper, 3 branch offset.
- `in_tag` in `TAG_W`: sideband tag.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out `OUT_W`: extended result.
- `out_tag` out `TAG_W`: tag of the current result.

## Operation
- Extension rules. All arithmetic is done at `OUT_W`; results are truncated to `OUT_W` bits.
  - Mode 0: upper `OUT_W-IN_W` bits are zero; `in_imm` occupies the low bits.
  - Mode 1: `in_imm[IN_W-1]` is replicated into the upper bits.
  - Mode 2: `in_imm` is shifted left by `OUT_W-IN_W`, zero-filled below. When `OUT_W==IN_W` this equals mode 0.
  - Mode 3: sign-extend as in mode 1, then shift left 2, zero-filled below.
- Extension is computed on the input side. The main and skid registers store the final value and tag, not raw fields.
- Storage:
  - Main register drives `out_*`.
  - Skid register holds one overflow entry.
- States, encoded by the main-full and skid-full bits:
  - EMPTY: main empty, skid empty.
  - ONE: main full, skid empty.
  - FULL: main full, skid full.
- Accept = `in_valid & in_ready`. Drain = `out_valid & out_ready`.
- Transitions:
  - EMPTY: accept → ONE, with main loaded.
  - ONE, accept & drain: main reloaded, stay in ONE.
  - ONE, accept without drain: skid loaded → FULL.
  - ONE, drain only: → EMPTY.
  - ONE, neither: hold.
  - FULL, drain: skid moves to main, skid cleared → ONE.
  - FULL, no drain: hold all contents.
- `in_ready` is registered:
  - Next value is 0 when the next state is FULL, else 1.
  - In FULL, `in_ready` is 0, so no accept can occur there.
- Ordering is strictly FIFO. No transaction is ever dropped or duplicated.
- `out_data`/`out_tag` hold stable while `out_valid & ~out_ready`.
- `in_mode` and `in_tag` are sampled only on accept. Changes to them while not accepting have no effect.

## Timing
- Reset (async assert, while `Rst_n`=0):
  - `out_valid`=0, `out_data`=0, `out_tag`=0, `in_ready`=1.
  - Skid register cleared; state EMPTY.
- Reset deassertion is synchronous to `Clk`, synchronised externally. The first edge after deassertion may accept.
- Reset asserted mid-operation: all buffered transactions are discarded immediately. Outputs take their reset values without waiting for a clock edge.
- Latency: an accept at edge N gives `out_valid`=1 with its result after edge N, i.e. visible in cycle N+1.
- Throughput: one transaction per cycle while `out_ready` is held high.
- After a stall:
  - `in_ready` returns to 1 in the cycle after the first drain out of FULL.
  - The skid entry appears on `out_*` in that same cycle.
- There is no combinational path from `out_ready` to `in_ready`, nor from `in_*` to `out_*`.

## Test plan
- **Modes.** Params 16/32. `in_imm`=0x8001, `out_ready`=1, modes 0..3 back-to-back, tags 1..4. Required: `out_data` = 0x00008001, 0xFFFF8001, 0x80010000, 0xFFFE0004 on four consecutive cycles, each one cycle after accept, with tags 1..4.
- **Positive/edge values.** `in_imm`=0x7FFF in mode 1 → 0x00007FFF. `in_imm`=0x0000 in mode 3 → 0x00000000. `in_imm`=0xFFFF in mode 3 → 0xFFFFFFFC.
- **Backpressure.**
  - Hold `out_ready`=0 and offer A, B, C on consecutive cycles.
  - Required: A and B accepted; `in_ready` goes 0 after the B accept; C is held; `out_data` stays A.
  - Then raise `out_ready`: outputs are A, B, C in order; `in_ready` returns to 1 the cycle after A drains.
- **Simultaneous accept and drain in ONE.** Required: state stays ONE, `in_ready` stays 1, and the new result replaces the old on the next cycle with no bubble.
- **Reset mid-operation.** In FULL, pulse `Rst_n` low between edges. Required: `out_valid`=0, `out_data`=0, `in_ready`=1 immediately. After release, the next accepted value is the first output; old entries never appear.
- **Parameter sweep.** `IN_W`=8, `OUT_W`=8, `in_imm`=0x81. Required: mode 0 → 0x81, mode 1 → 0x81, mode 2 → 0x81, mode 3 → 0x04.
